// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic LINE_IDLE     = 1'b1;
  localparam int   MAX_DATA_BITS = 9;

  // Even parity of the (zero-extended) data word, inverted for odd parity.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; rdata shows the head entry combinationally.
// Caller must not push when full or pop when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART TX: FIFO feeding an LSB-first serialiser; start bit 2 cycles after push into an idle block.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd) between data and stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = 4;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 load;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
  logic [MAX_DATA_BITS-1:0] par_in;

  always_comb begin
    par_in                  = '0;
    par_in[DATA_BITS-1:0]   = fifo_rdata;
  end
`endif

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign bit_end   = (baud_q == CNT_W'(CLK_DIV - 1));

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    // Restarting at every bit boundary keeps each serial bit exactly CLK_DIV cycles.
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) load = 1'b1;
            else             state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      state_d  = START;
      bit_d    = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_bit(par_in, PARITY_ODD != 0);
`endif
    end

    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = LINE_IDLE;
    endcase

    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= LINE_IDLE;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model on one instance plus directed literal checks.
module tb_uart_tx_fifo;

  localparam int CD    = 4;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB1 = 1 + DB + P + SB;
  localparam int L1  = NB1 * CD;
  localparam int NB2 = 1 + 7 + P + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, txd, busy;
  logic [2:0] fifo_level;

  logic [6:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2, txd2, busy2;
  logic [2:0] fifo_level2;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(
    .CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)
  ) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .txd(txd2), .busy(busy2), .fifo_level(fifo_level2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, the serialiser as "edges left in the current frame".
  logic [7:0] mq[$];
  int         m_remain = 0;
  logic [7:0] m_word   = '0;
  logic       m_sd     = 1'b1;
  logic       m_txd    = 1'b1;
  logic       m_busy   = 1'b0;
  bit         chk_en   = 1'b0;

  function automatic logic frame_bit(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return w[idx-1];
    if (P == 1 && idx == DB + 1) return ^w;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit do_push;
    if (rst) begin
      mq.delete();
      m_remain = 0;
      m_sd     = 1'b1;
      m_txd    = 1'b1;
      m_busy   = 1'b0;
    end else begin
      m_txd   = m_sd;
      m_busy  = (m_remain > 0) || (mq.size() > 0);
      do_push = tx_valid && (mq.size() < DEPTH);
      if (m_remain <= 1 && mq.size() > 0) begin
        m_word   = mq.pop_front();
        m_remain = L1;
      end else if (m_remain > 0) begin
        m_remain--;
      end
      if (do_push) mq.push_back(tx_data);
      m_sd = (m_remain > 0) ? frame_bit(m_word, (L1 - m_remain) / CD) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_txd",      int'(txd),        int'(m_txd));
      check("model_busy",     int'(busy),       int'(m_busy));
      check("model_level",    int'(fifo_level), mq.size());
      check("model_tx_ready", int'(tx_ready),   int'(mq.size() < DEPTH));
    end
  end

`ifdef UART_TX_PARITY_EN
  int e55[NB1] = '{0, 1,0,1,0,1,0,1,0, 0, 1};
  int e07[NB1] = '{0, 1,1,1,0,0,0,0,0, 1, 1};
  int e2[2*NB2] = '{0, 0,1,0,0,1,0,0, 1, 1,1,
                    0, 0,0,1,0,1,1,0, 0, 1,1};
`else
  int e55[NB1] = '{0, 1,0,1,0,1,0,1,0, 1};
  int e07[NB1] = '{0, 1,1,1,0,0,0,0,0, 1};
  int e2[2*NB2] = '{0, 0,1,0,0,1,0,0, 1,1,
                    0, 0,0,1,0,1,1,0, 1,1};
`endif

  int cap1[NB1];
  int cap2[2*NB2];

  // Push one word into idle dut, then capture mid-bit txd and the busy span from the start bit.
  task automatic run_frame1(input logic [7:0] w, input string tag, output int blen);
    @(negedge clk); tx_valid = 1'b1; tx_data = w;
    @(negedge clk); tx_valid = 1'b0;
    @(negedge clk); check({tag, "_pre_start_high"}, int'(txd), 1);
    @(negedge clk); check({tag, "_start_latency"},  int'(txd), 0);
    blen = 0;
    for (int c = 0; c < 400; c++) begin
      if (c % CD == 1 && c / CD < NB1) cap1[c / CD] = int'(txd);
      if (busy) blen++;
      else break;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int blen, idle_bad, idx, cyc, lows, highs, lvl4, rdy4;
    int acc[6];
    logic [7:0] fw[6];
    bit acc_ok, found;

    fw = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_txd",      int'(txd),        1);
    check("reset_tx_ready", int'(tx_ready),   1);
    check("reset_busy",     int'(busy),       0);
    check("reset_level",    int'(fifo_level), 0);
    check("reset_txd2",     int'(txd2),       1);

    idle_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    check("idle_stable", idle_bad, 0);

    run_frame1(8'h55, "f55", blen);
    for (int k = 0; k < NB1; k++) check($sformatf("f55_bit%0d", k), cap1[k], e55[k]);
    check("f55_frame_len", blen, L1);

    run_frame1(8'h07, "f07", blen);
    for (int k = 0; k < NB1; k++) check($sformatf("f07_bit%0d", k), cap1[k], e07[k]);
    check("f07_frame_len", blen, L1);

    // Offer six words continuously; tx_ready at the negedge predicts acceptance at the next edge.
    idx = 0; cyc = 0; lvl4 = -1; rdy4 = -1;
    @(negedge clk); tx_valid = 1'b1;
    while (idx < 6 && cyc < 500) begin
      tx_data = fw[idx];
      acc_ok  = tx_ready;
      @(negedge clk);
      cyc++;
      if (acc_ok) begin
        acc[idx] = cyc;
        if (idx == 4) begin lvl4 = int'(fifo_level); rdy4 = int'(tx_ready); end
        idx++;
      end
    end
    tx_valid = 1'b0;
    check("full_accepted", idx, 6);
    for (int k = 0; k < 5; k++) check($sformatf("full_acc_cycle%0d", k), acc[k], k + 1);
    check("full_level", lvl4, 4);
    check("full_tx_ready", rdy4, 0);
    check("full_sixth_cycle", acc[5], L1 + 3);
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("drain_done", int'(found), 1);

    // Reset during data bit 3 with two words queued behind the active frame.
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_data = 8'hC3;
    @(negedge clk); tx_data = 8'h5A;
    @(negedge clk); tx_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (!txd) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_start_seen", int'(found), 1);
    repeat (17) @(negedge clk);
    check("pre_reset_level", int'(fifo_level), 2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("post_reset_txd",      int'(txd),        1);
    check("post_reset_level",    int'(fifo_level), 0);
    check("post_reset_busy",     int'(busy),       0);
    check("post_reset_tx_ready", int'(tx_ready),   1);
    lows = 0; highs = 0;
    repeat (200) begin
      @(negedge clk);
      if (!txd) lows++;
      if (busy) highs++;
    end
    check("post_reset_no_start", lows, 0);
    check("post_reset_no_busy", highs, 0);

    // 7 data bits, 2 stop bits, odd parity: two frames back-to-back.
    @(negedge clk); tx_valid2 = 1'b1; tx_data2 = 7'h12;
    @(negedge clk); tx_data2 = 7'h34;
    @(negedge clk); tx_valid2 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (!txd2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_start_seen", int'(found), 1);
    @(negedge clk);
    for (int k = 0; k < 2 * NB2; k++) begin
      cap2[k] = int'(txd2);
      if (k < 2 * NB2 - 1) repeat (CD) @(negedge clk);
    end
    for (int k = 0; k < 2 * NB2; k++) check($sformatf("b2b_bit%0d", k), cap2[k], e2[k]);
    repeat (2) @(negedge clk);
    check("b2b_busy_last_stop", int'(busy2), 1);
    @(negedge clk);
    check("b2b_busy_fall", int'(busy2), 0);
    check("b2b_txd_idle", int'(txd2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter, successor to the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO. Each word is serialised LSB-first on `txd` with a programmable bit period, data width and stop-bit count, plus optional parity. It sits between the scope's sample/command formatter and the board TX pin, and removes the need for the producer to poll a busy flag per byte.

## Interface
- `CLK_DIV`, 5208: clock cycles per bit period, ≥2 (5208 = 9600 baud at 50 MHz).
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, ≥2.
- `PARITY_ODD`, 0: 0 = even, 1 = odd parity. Used only when parity is compiled in.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  DATA_BITS  word to send.
- `tx_valid`  in  1  `tx_data` is valid this cycle.
- `tx_ready`  out  1  FIFO can accept a word; equals !full, combinational from FIFO count.
- `txd`  out  1  serial line, registered, idles high.
- `busy`  out  1  registered; high while the FSM is not IDLE or the FIFO is non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push occurs when `tx_valid && tx_ready` at a rising edge. Data is captured and the count increments.
- The FIFO has no bypass. Words always pass through the FIFO.
- A pop and a push in the same cycle leave the count unchanged.
- When full, `tx_ready` is low, so no push can occur even if a pop happens that cycle.
- FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register, compute parity, go to START.
  - START: `txd`=0 for one bit period, then go to DATA.
  - DATA: shift out `DATA_BITS` bits LSB-first, one per bit period, tracked by a bit counter. Then go to PARITY if compiled in, otherwise STOP.
  - PARITY: one bit period carrying the parity bit.
  - STOP: `txd`=1 for `STOP_BITS` bit periods. At the end, pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and is cleared on every state entry from IDLE or STOP.
  - bit_end = (count == CLK_DIV-1).
  - Every serial bit lasts exactly CLK_DIV cycles.
- Parity is the XOR of the `DATA_BITS` data bits, inverted when `PARITY_ODD`=1.
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0, FSM=IDLE, baud and bit counters 0.
- Reset mid-frame aborts the frame, clears the FIFO, and drives `txd` high from the next cycle.

## Timing
- From idle, a word pushed at edge N is popped at edge N+1 and `txd` falls after edge N+2. Push-to-start-bit latency is 2 cycles.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, with P = 1 when parity is compiled in, otherwise 0.
- Back-to-back frames have no idle gap. The start bit begins the cycle after the last stop-bit cycle.
- `busy` falls the cycle after the last stop bit if the FIFO is empty.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are present, and `PARITY_ODD` is honoured.
- Not defined: there is no PARITY state, frames are 1+DATA_BITS+STOP_BITS bits, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Line idle level constant (1).
  - Parity helper function.
- Sub-module `uart_sync_fifo`: synchronous FIFO with count. Parameters are width and depth. Ports are push, pop, wdata, rdata, full, empty, level.
- The top level contains the FSM, the baud counter, the bit counter and the shift register.

## Test plan
- 8N1 (CLK_DIV=4, no parity): push 0x55 -> `txd` 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; the start bit falls 2 cycles after the push; frame lasts 40 cycles; `busy` is high throughout.
- Parity (macro on, CLK_DIV=4): 0x55 even -> parity bit 0; 0x07 even -> 1; 0x07 with `PARITY_ODD`=1 -> 0; frame lasts 44 cycles.
- FIFO full (DEPTH=4): offer 6 words back-to-back from idle -> 5 are accepted in 5 cycles (the first is popped at cycle 2), `fifo_level` reaches 4 and `tx_ready` goes low; the 6th is accepted the cycle after the first frame's stop bit ends.
- Back-to-back with STOP_BITS=2, DATA_BITS=7: push 0x12, 0x34 -> each frame is 10×CLK_DIV cycles with no high gap beyond the 2 stop bits; 7 data bits are observed per frame.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 3 with 2 words queued -> `txd`=1 the next cycle, `fifo_level`=0, `busy`=0, and no further start bit appears.
- Idle stability: no pushes for 1000 cycles -> `txd` stays 1, `tx_ready` stays 1, `busy` stays 0.
